// File: rtl/sudoku_ctrl_pkg.sv
// Shared types and constants for the Sudoku game controllers: top-level game
// states, the digit-commit sequencer states, and board geometry helpers.
package sudoku_ctrl_pkg;

    typedef enum logic [1:0] {
        SMENU = 2'd0,
        SGAME = 2'd1,
        SOVER = 2'd2
    } top_state_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PREDICT = 3'd2,
        COMMIT  = 3'd3,
        CLEAR   = 3'd4
    } commit_state_t;

    localparam int         CELL_COUNT = 81;
    localparam logic [3:0] DIGIT_MIN  = 4'd1;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] COORD_MAX  = 4'd8;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } cell_t;

    // Row-major board index; callers must range-check row/col first.
    function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return 7'(row) * 7'd9 + 7'(col);
    endfunction

endpackage

// File: rtl/digit_commit_ctrl_if.sv
// Stroke, predictor and solver-write handshake bundle for digit_commit_ctrl.
// master = the commit controller, slave = the surrounding game logic.
interface digit_commit_ctrl_if;
    logic       draw_valid;
    logic [3:0] draw_row;
    logic [3:0] draw_col;
    logic       pred_start;
    logic       pred_finish;
    logic [3:0] pred_digit;
    logic       wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [3:0] wr_data;
    logic       clear_track;

    modport master (
        input  draw_valid, draw_row, draw_col, pred_finish, pred_digit,
        output pred_start, wr_en, wr_row, wr_col, wr_data, clear_track
    );

    modport slave (
        output draw_valid, draw_row, draw_col, pred_finish, pred_digit,
        input  pred_start, wr_en, wr_row, wr_col, wr_data, clear_track
    );
endinterface

// File: rtl/timeout_counter.sv
// Predictor watchdog: start clears and runs the count, stop halts it.
// expired flags the last cycle in which a predictor finish can still be taken.
module timeout_counter #(
    parameter int CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic expired
);
    localparam int W = $clog2(CYCLES);

    logic [W-1:0] cnt;
    logic         running;

    // Firing one count early lets the owner register its timeout pulse so it
    // lands exactly when the count would reach CYCLES-1.
    assign expired = running && (cnt == W'(CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
        end else if (stop || expired) begin
            running <= 1'b0;
        end else if (running) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/digit_commit_ctrl.sv
// Sequences one handwritten digit from stroke completion through prediction to
// a solver write, with a one-entry pending slot for strokes arriving while busy.
module digit_commit_ctrl
    import sudoku_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  game_active,
    input  logic [CELL_COUNT-1:0] cell_editable,
    digit_commit_ctrl_if.master   bus,
    output logic                  busy,
    output logic                  reject,
    output logic                  timeout,
    output logic                  drop
);
    commit_state_t state, state_n;
    cell_t         work, work_n;
    cell_t         pend, pend_n;
    logic          pend_vld, pend_vld_n;
    cell_t         draw_cell;
    logic          in_range, cell_ok, digit_ok;
    logic [6:0]    idx;
    logic          expired, cnt_start, cnt_stop;
    logic          pstart_n, wr_n, clear_n, reject_n, timeout_n, drop_n;

    assign draw_cell = {bus.draw_row, bus.draw_col};
    assign busy      = (state != IDLE);

    assign in_range = (work.row <= COORD_MAX) && (work.col <= COORD_MAX);
    assign idx      = in_range ? cell_index(work.row, work.col) : 7'd0;
    assign cell_ok  = in_range && cell_editable[idx];
    assign digit_ok = (bus.pred_digit >= DIGIT_MIN) && (bus.pred_digit <= DIGIT_MAX);

    assign cnt_start = pstart_n;
    assign cnt_stop  = (state == PREDICT) && (state_n != PREDICT);

    timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (cnt_start),
        .stop    (cnt_stop),
        .expired (expired)
    );

    always_comb begin
        state_n    = state;
        work_n     = work;
        pend_n     = pend;
        pend_vld_n = pend_vld;
        pstart_n   = 1'b0;
        wr_n       = 1'b0;
        clear_n    = 1'b0;
        reject_n   = 1'b0;
        timeout_n  = 1'b0;
        drop_n     = 1'b0;

        if (!game_active) begin
            state_n    = IDLE;
            pend_vld_n = 1'b0;
            clear_n    = (state != IDLE) && (state != CLEAR);
        end else begin
            unique case (state)
                IDLE: begin
                    if (pend_vld) begin
                        work_n     = pend;
                        pend_vld_n = bus.draw_valid;
                        if (bus.draw_valid) pend_n = draw_cell;
                        state_n    = CHECK;
                    end else if (bus.draw_valid) begin
                        work_n  = draw_cell;
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (!cell_ok) begin
                        reject_n = 1'b1;
                        state_n  = CLEAR;
                    end else begin
                        pstart_n = 1'b1;
                        state_n  = PREDICT;
                    end
                end
                PREDICT: begin
                    // pred_start is high only in the first PREDICT cycle, so it
                    // doubles as the "finish not yet accepted" qualifier.
                    if (bus.pred_finish && !bus.pred_start) begin
                        if (digit_ok) begin
                            wr_n    = 1'b1;
                            state_n = COMMIT;
                        end else begin
                            reject_n = 1'b1;
                            state_n  = CLEAR;
                        end
                    end else if (expired) begin
                        timeout_n = 1'b1;
                        state_n   = CLEAR;
                    end
                end
                COMMIT:  state_n = CLEAR;
                CLEAR:   state_n = IDLE;
                default: state_n = IDLE;
            endcase

            if (state != IDLE && bus.draw_valid) begin
                if (!pend_vld) begin
                    pend_vld_n = 1'b1;
                    pend_n     = draw_cell;
                end else begin
                    drop_n = 1'b1;
                end
            end
            clear_n = (state_n == CLEAR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            work            <= '0;
            pend            <= '0;
            pend_vld        <= 1'b0;
            bus.pred_start  <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.wr_row      <= '0;
            bus.wr_col      <= '0;
            bus.wr_data     <= '0;
            bus.clear_track <= 1'b0;
            reject          <= 1'b0;
            timeout         <= 1'b0;
            drop            <= 1'b0;
        end else begin
            state           <= state_n;
            work            <= work_n;
            pend            <= pend_n;
            pend_vld        <= pend_vld_n;
            bus.pred_start  <= pstart_n;
            bus.wr_en       <= wr_n;
            bus.clear_track <= clear_n;
            reject          <= reject_n;
            timeout         <= timeout_n;
            drop            <= drop_n;
            if (wr_n) begin
                bus.wr_row  <= work.row;
                bus.wr_col  <= work.col;
                bus.wr_data <= bus.pred_digit;
            end
        end
    end
endmodule

// File: tb/tb_digit_commit_ctrl.sv
// Directed bench for digit_commit_ctrl with a 16-cycle predictor timeout.
module tb_digit_commit_ctrl;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_active = 1'b1;
    logic [80:0] editable;
    logic        busy, reject, timeout, drop;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    int n_ps = 0, n_wr = 0, n_cl = 0, n_rj = 0, n_to = 0, n_dr = 0;
    int t_ps = -1, t_wr = -1, t_cl = -1, t_rj = -1, t_to = -1, t_dr = -1, t_busy = -1;
    logic [3:0] w_row = 0, w_col = 0, w_data = 0;
    int b_ps, b_wr, b_cl, b_rj, b_to, b_dr;

    digit_commit_ctrl_if bus ();

    digit_commit_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .game_active   (game_active),
        .cell_editable (editable),
        .bus           (bus),
        .busy          (busy),
        .reject        (reject),
        .timeout       (timeout),
        .drop          (drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pred_start)  begin n_ps++; t_ps = cyc; end
            if (bus.clear_track) begin n_cl++; t_cl = cyc; end
            if (reject)          begin n_rj++; t_rj = cyc; end
            if (timeout)         begin n_to++; t_to = cyc; end
            if (drop)            begin n_dr++; t_dr = cyc; end
            if (busy)            t_busy = cyc;
            if (bus.wr_en) begin
                n_wr++; t_wr = cyc;
                w_row = bus.wr_row; w_col = bus.wr_col; w_data = bus.wr_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic snap();
        b_ps = n_ps; b_wr = n_wr; b_cl = n_cl; b_rj = n_rj; b_to = n_to; b_dr = n_dr;
    endtask

    task automatic stroke(input logic [3:0] r, input logic [3:0] c, output int t0);
        bus.draw_valid = 1'b1; bus.draw_row = r; bus.draw_col = c;
        t0 = cyc;
        tick();
        bus.draw_valid = 1'b0;
    endtask

    task automatic finish_at(input int f, input logic [3:0] d);
        tick_to(f);
        bus.pred_finish = 1'b1; bus.pred_digit = d;
        tick();
        bus.pred_finish = 1'b0; bus.pred_digit = 4'd0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.pred_start, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, bus.clear_track, reject, timeout, drop} !== 18'd0) begin failures++; $display("FAIL reset_outputs got %h exp 0", {bus.pred_start, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, bus.clear_track, reject, timeout, drop}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_accept();
        int c0;
        snap();
        stroke(4'd2, 4'd3, c0);
        finish_at(c0 + 5, 4'd7);
        tick_to(c0 + 12);
        checks++; if (n_ps - b_ps !== 1 || t_ps !== c0 + 2) begin failures++; $display("FAIL acc_pstart got n=%0d t=%0d exp n=1 t=%0d", n_ps - b_ps, t_ps, c0 + 2); end
        checks++; if (n_wr - b_wr !== 1 || t_wr !== c0 + 6) begin failures++; $display("FAIL acc_wr got n=%0d t=%0d exp n=1 t=%0d", n_wr - b_wr, t_wr, c0 + 6); end
        checks++; if ({w_row, w_col, w_data} !== {4'd2, 4'd3, 4'd7}) begin failures++; $display("FAIL acc_wr_fields got %0d,%0d,%0d exp 2,3,7", w_row, w_col, w_data); end
        checks++; if (n_cl - b_cl !== 1 || t_cl !== c0 + 7) begin failures++; $display("FAIL acc_clear got n=%0d t=%0d exp n=1 t=%0d", n_cl - b_cl, t_cl, c0 + 7); end
        checks++; if (t_busy !== c0 + 7) begin failures++; $display("FAIL acc_busy_last got %0d exp %0d", t_busy, c0 + 7); end
        checks++; if (n_rj - b_rj !== 0) begin failures++; $display("FAIL acc_no_reject got %0d exp 0", n_rj - b_rj); end
    endtask

    task automatic test_reject_cell(input logic [3:0] r, input logic [3:0] c, input string nm);
        int c0;
        snap();
        stroke(r, c, c0);
        tick_to(c0 + 6);
        checks++; if (n_rj - b_rj !== 1 || t_rj !== c0 + 2) begin failures++; $display("FAIL %s_reject got n=%0d t=%0d exp n=1 t=%0d", nm, n_rj - b_rj, t_rj, c0 + 2); end
        checks++; if (n_cl - b_cl !== 1 || t_cl !== c0 + 2) begin failures++; $display("FAIL %s_clear got n=%0d t=%0d exp n=1 t=%0d", nm, n_cl - b_cl, t_cl, c0 + 2); end
        checks++; if (n_ps - b_ps !== 0 || n_wr - b_wr !== 0) begin failures++; $display("FAIL %s_no_launch got ps=%0d wr=%0d exp 0,0", nm, n_ps - b_ps, n_wr - b_wr); end
    endtask

    task automatic test_bad_digit(input logic [3:0] d, input int lat);
        int c0;
        snap();
        stroke(4'd1, 4'd1, c0);
        finish_at(c0 + 2 + lat, d);
        tick_to(c0 + 10);
        checks++; if (n_rj - b_rj !== 1 || t_rj !== c0 + 3 + lat) begin failures++; $display("FAIL digit%0d_reject got n=%0d t=%0d exp n=1 t=%0d", d, n_rj - b_rj, t_rj, c0 + 3 + lat); end
        checks++; if (n_wr - b_wr !== 0 || n_cl - b_cl !== 1) begin failures++; $display("FAIL digit%0d_nowr got wr=%0d cl=%0d exp 0,1", d, n_wr - b_wr, n_cl - b_cl); end
    endtask

    task automatic test_boundary();
        int c0;
        snap();
        stroke(4'd8, 4'd8, c0);
        finish_at(c0 + 3, 4'd9);
        tick_to(c0 + 8);
        checks++; if (n_wr - b_wr !== 1 || {w_row, w_col, w_data} !== {4'd8, 4'd8, 4'd9} || t_wr !== c0 + 4) begin failures++; $display("FAIL edge_88 got n=%0d %0d,%0d,%0d t=%0d exp n=1 8,8,9 t=%0d", n_wr - b_wr, w_row, w_col, w_data, t_wr, c0 + 4); end
    endtask

    task automatic test_timeout();
        int c0;
        snap();
        stroke(4'd5, 4'd5, c0);
        tick_to(c0 + 25);
        checks++; if (n_to - b_to !== 1 || t_to !== c0 + 2 + TMO - 1) begin failures++; $display("FAIL tmo_pulse got n=%0d t=%0d exp n=1 t=%0d", n_to - b_to, t_to, c0 + 2 + TMO - 1); end
        checks++; if (n_cl - b_cl !== 1 || t_cl !== c0 + 2 + TMO - 1) begin failures++; $display("FAIL tmo_clear got n=%0d t=%0d exp n=1 t=%0d", n_cl - b_cl, t_cl, c0 + 2 + TMO - 1); end
        checks++; if (n_wr - b_wr !== 0 || n_rj - b_rj !== 0) begin failures++; $display("FAIL tmo_side got wr=%0d rj=%0d exp 0,0", n_wr - b_wr, n_rj - b_rj); end
    endtask

    task automatic test_back_to_back();
        int c0, cb, cc;
        snap();
        stroke(4'd2, 4'd3, c0);
        stroke(4'd3, 4'd4, cb);
        stroke(4'd4, 4'd5, cc);
        finish_at(c0 + 5, 4'd7);
        finish_at(c0 + 12, 4'd4);
        tick_to(c0 + 18);
        checks++; if (n_dr - b_dr !== 1 || t_dr !== c0 + 3) begin failures++; $display("FAIL b2b_drop got n=%0d t=%0d exp n=1 t=%0d", n_dr - b_dr, t_dr, c0 + 3); end
        checks++; if (n_ps - b_ps !== 2 || t_ps !== c0 + 10) begin failures++; $display("FAIL b2b_pstart got n=%0d t=%0d exp n=2 t=%0d", n_ps - b_ps, t_ps, c0 + 10); end
        checks++; if (n_wr - b_wr !== 2 || {w_row, w_col, w_data} !== {4'd3, 4'd4, 4'd4} || t_wr !== c0 + 13) begin failures++; $display("FAIL b2b_wr got n=%0d %0d,%0d,%0d t=%0d exp n=2 3,4,4 t=%0d", n_wr - b_wr, w_row, w_col, w_data, t_wr, c0 + 13); end
        checks++; if (n_cl - b_cl !== 2 || t_busy !== c0 + 14) begin failures++; $display("FAIL b2b_end got cl=%0d busy_last=%0d exp 2,%0d", n_cl - b_cl, t_busy, c0 + 14); end
    endtask

    task automatic test_game_inactive();
        int c0, cb, cx;
        snap();
        stroke(4'd2, 4'd3, c0);
        stroke(4'd3, 4'd4, cb);
        tick_to(c0 + 3);
        game_active = 1'b0;
        stroke(4'd6, 4'd6, cx);
        game_active = 1'b1;
        tick_to(c0 + 14);
        checks++; if (n_cl - b_cl !== 1 || t_cl !== c0 + 4) begin failures++; $display("FAIL ga_clear got n=%0d t=%0d exp n=1 t=%0d", n_cl - b_cl, t_cl, c0 + 4); end
        checks++; if (n_ps - b_ps !== 1 || n_wr - b_wr !== 0) begin failures++; $display("FAIL ga_slot_empty got ps=%0d wr=%0d exp 1,0", n_ps - b_ps, n_wr - b_wr); end
        checks++; if (t_busy !== c0 + 3 || n_dr - b_dr !== 0) begin failures++; $display("FAIL ga_idle got busy_last=%0d drop=%0d exp %0d,0", t_busy, n_dr - b_dr, c0 + 3); end
    endtask

    task automatic test_reset_mid();
        int c0;
        snap();
        stroke(4'd2, 4'd3, c0);
        tick_to(c0 + 5);
        bus.pred_finish = 1'b1; bus.pred_digit = 4'd7;
        tick();
        bus.pred_finish = 1'b0; bus.pred_digit = 4'd0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_now got wr=%b busy=%b exp 0,0", bus.wr_en, busy); end
        tick(); tick();
        rst_n = 1'b1;
        tick_to(c0 + 14);
        checks++; if (n_wr - b_wr !== 0 || n_cl - b_cl !== 0 || n_ps - b_ps !== 1) begin failures++; $display("FAIL rst_mid_after got wr=%0d cl=%0d ps=%0d exp 0,0,1", n_wr - b_wr, n_cl - b_cl, n_ps - b_ps); end
    endtask

    initial begin
        editable = {81{1'b1}};
        editable[0] = 1'b0;
        bus.draw_valid = 1'b0; bus.draw_row = 4'd0; bus.draw_col = 4'd0;
        bus.pred_finish = 1'b0; bus.pred_digit = 4'd0;
        test_reset();
        test_accept();
        test_reject_cell(4'd0, 4'd0, "cell00");
        test_reject_cell(4'd9, 4'd0, "row9");
        test_reject_cell(4'd4, 4'd9, "col9");
        test_bad_digit(4'd0, 1);
        test_bad_digit(4'd12, 2);
        test_boundary();
        test_timeout();
        test_back_to_back();
        test_game_inactive();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/digit_commit_ctrl.md
# digit_commit_ctrl

Sequences one handwritten-digit entry from stroke completion to board update during gameplay. It accepts the stroke-done pulse and target cell from the mouse-draw block, launches the digit predictor, checks its result, and writes the digit into the Sudoku solver through the solver's single write port. It then clears the drawing track. A one-entry pending slot absorbs a new stroke that finishes while an entry is still being processed.

## Interface
- TIMEOUT_CYCLES, 2_000_000, maximum cycles to wait for `pred_finish` after `pred_start` (20 ms at 100 MHz); must be ≥2
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- game_active  in  1  high while the top FSM is in SGAME
- draw_valid  in  1  one-cycle pulse: a stroke is complete
- draw_row  in  4  target cell row, sampled with `draw_valid`
- draw_col  in  4  target cell column, sampled with `draw_valid`
- cell_editable  in  81  1 = cell was blank in the generated puzzle; bit index = row*9+col
- pred_start  out  1  one-cycle pulse that launches the predictor
- pred_finish  in  1  predictor done; level or pulse
- pred_digit  in  4  predicted digit, valid when `pred_finish` is high
- wr_en  out  1  one-cycle write strobe to the solver
- wr_row  out  4  write row
- wr_col  out  4  write column
- wr_data  out  4  digit to write
- clear_track  out  1  one-cycle pulse that clears the MouseDraw track
- busy  out  1  high in every state except IDLE
- reject  out  1  one-cycle pulse: illegal cell or illegal digit
- timeout  out  1  one-cycle pulse: predictor timed out
- drop  out  1  one-cycle pulse: stroke lost because the pending slot was full

## Operation
- States are IDLE, CHECK, PREDICT, COMMIT, CLEAR.
- **IDLE**
  - If the pending slot is full, load it into the work registers, empty it, and go to CHECK.
  - Otherwise, on `draw_valid`, load `draw_row`/`draw_col` into the work registers and go to CHECK.
  - If the slot is full and `draw_valid` arrives in the same cycle, the slot's entry goes to work and the new stroke goes into the slot.
- **CHECK**
  - If row>8, col>8, or `cell_editable[row*9+col]`=0: pulse `reject` and go to CLEAR.
  - Otherwise go to PREDICT.
- **PREDICT**
  - `pred_start` is high for the first PREDICT cycle only.
  - The timeout counter starts from 0 in that cycle.
  - From the second PREDICT cycle, `pred_finish`=1 with `pred_digit` in 1..9 latches the digit and moves to COMMIT.
  - `pred_finish`=1 with `pred_digit` equal to 0 or greater than 9 pulses `reject` and moves to CLEAR.
  - If the counter reaches TIMEOUT_CYCLES-1 with no finish, pulse `timeout` and go to CLEAR.
  - If finish and timeout happen in the same cycle, finish wins.
- **COMMIT**: `wr_en`=1 for one cycle with the work row/col and the latched digit; then go to CLEAR.
- **CLEAR**: `clear_track`=1 for one cycle; then go to IDLE.
- **`draw_valid` while not in IDLE**
  - If the slot is empty, capture the stroke into it.
  - If the slot is full, pulse `drop` and keep the older entry.
- **`game_active`=0**
  - Synchronously forces IDLE from any state and empties the pending slot.
  - No `wr_en` or `pred_start` is issued in that cycle.
  - `clear_track` pulses once if the state was not IDLE.
  - `draw_valid` is ignored while `game_active` is low.
- **Arithmetic**: cell index is the 7-bit value row*9+col, computed only after the range check passes. The counter width is $clog2(TIMEOUT_CYCLES).

## Timing
- **Reset**: all outputs are 0, state is IDLE, the pending slot is empty, and the counter is 0.
- All outputs are registered or Moore-decoded from state; there are no combinational paths from inputs to outputs.
- **Accepted entry**
  - `draw_valid` at cycle 0 puts the block in CHECK at cycle 1, with `pred_start` at cycle 2.
  - `pred_finish` sampled at cycle F (F≥3) gives `wr_en` at F+1, `clear_track` at F+2, and IDLE at F+3.
- **Rejected entry**: `draw_valid` at cycle 0 gives `reject` during CLEAR entry (cycle 2) and `clear_track` at cycle 2.
- **Timeout**: with `pred_start` at cycle 2, `timeout` is asserted at cycle 2+TIMEOUT_CYCLES-1.
- **Back-to-back**: a pending entry enters CHECK one cycle after IDLE is re-entered.
- **Reset mid-operation**: state and all outputs clear immediately; no partial write is issued.

## Structure
- Package `sudoku_ctrl_pkg` holds:
  - the state enum `commit_state_t`
  - `CELL_COUNT`=81
  - `DIGIT_MIN`=1 and `DIGIT_MAX`=9
  - the function `cell_index(row,col)`
- Top FSM state codes SMENU/SGAME/SOVER also move into `sudoku_ctrl_pkg`.
- One sub-module, `timeout_counter`, with ports:
  - `clk`, `rst_n`
  - `start`: synchronous clear-and-run
  - `stop`
  - `expired`: one-cycle pulse

## Test plan
- Stroke at (2,3) with `cell_editable[21]`=1; predictor returns 7 three cycles after `pred_start` → exactly one `wr_en` with row 2, col 3, data 7, then `clear_track` on the next cycle, then `busy` falls.
- Stroke at (0,0) with `cell_editable[0]`=0 → `reject`, `clear_track`, no `pred_start`, no `wr_en`.
- Predictor returns 0, then a separate run returns 12 → `reject` each time, no `wr_en`.
- Predictor never finishes (TIMEOUT_CYCLES=16) → `timeout` 15 cycles after `pred_start`, then `clear_track`.
- Three strokes during one busy entry → second is queued and processed with `pred_start` right after the first entry's CLEAR/IDLE; third raises `drop`.
- `game_active` drops during PREDICT with a stroke pending, then `rst_n` is asserted mid-COMMIT in a separate run → IDLE, slot empty, no `wr_en` in either case.
